instruction_fetch_unit: RTL

//  IF stage feeding pipeline_datapath: holds the PC and fetches from the instruction memory over a req/ack handshake.

---
 rtl/instruction_fetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, req/ack fetch FSM, 1-entry skid buffer, redirect squash.
// Optional perf counters under FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branchTarget,
  input  logic        endProgram,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcPlus4,
  output logic [31:0] preInstruction,
  output logic        ifIdWrIn,
  output logic        fetchError,
  output logic [31:0] bubbleCount,
  output logic [31:0] stallCount
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HALT,
    ERR
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] reqAddr;
  logic [31:0] bufPc;
  logic [31:0] bufInstr;
  logic        bufValid;
  logic        squash;
  logic        endPending;
  logic [3:0]  waitCnt;

  logic        redirect;
  logic        ack;
  logic        fill;
  logic        endReq;

  assign redirect = branch & ~stall;
  // a full buffer under stall has nowhere to put returning data
  assign imemReq  = (state == REQ) & ~(bufValid & stall);
  assign ack      = imemReq & imemAck;
  assign fill     = ack & ~squash & ~redirect;
  assign endReq   = endProgram | endPending;

  assign imemAddr       = (state == REQ && squash) ? reqAddr : pc;
  assign ifIdWrIn       = ~stall & ~reset;
  assign preInstruction = bufValid ? bufInstr : NOP_INSTR;
  assign pcPlus4        = (bufValid ? bufPc : pc) + 32'd4;
  assign fetchError     = (state == ERR);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (endReq)
          stateNext = HALT;
        else if (~bufValid | ~stall)
          stateNext = REQ;
      end
      REQ: begin
        if (ack) begin
          if (endReq)
            stateNext = HALT;
          else if (squash)
            stateNext = IDLE;
          else if (~stall)
            stateNext = REQ;
          else
            stateNext = IDLE;
        end else if (imemReq && waitCnt == WAIT_LIMIT) begin
          stateNext = ERR;
        end
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      reqAddr    <= RESET_PC;
      bufPc      <= RESET_PC;
      bufInstr   <= NOP_INSTR;
      bufValid   <= 1'b0;
      squash     <= 1'b0;
      endPending <= 1'b0;
      waitCnt    <= 4'd0;
    end else begin
      state <= stateNext;

      if (redirect)
        pc <= branchTarget;
      else if (fill)
        pc <= pc + 32'd4;

      if (redirect) begin
        bufValid <= 1'b0;
      end else if (fill) begin
        bufValid <= 1'b1;
        bufPc    <= pc;
        bufInstr <= imemRdata;
      end else if (~stall) begin
        bufValid <= 1'b0;
      end

      // memory still owes the old address; keep it on the bus
      if (ack)
        squash <= 1'b0;
      else if (redirect && imemReq)
        squash <= 1'b1;

      if (redirect && imemReq && !ack && !squash)
        reqAddr <= pc;

      if (endProgram)
        endPending <= 1'b1;

      if (ack || state != REQ)
        waitCnt <= 4'd0;
      else if (imemReq)
        waitCnt <= waitCnt + 4'd1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubbleCnt;
  logic [31:0] stallCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbleCnt <= 32'h0;
      stallCnt  <= 32'h0;
    end else begin
      if (ifIdWrIn && !bufValid && bubbleCnt != 32'hFFFF_FFFF)
        bubbleCnt <= bubbleCnt + 32'd1;
      if (stall && stallCnt != 32'hFFFF_FFFF)
        stallCnt <= stallCnt + 32'd1;
    end
  end

  assign bubbleCount = bubbleCnt;
  assign stallCount  = stallCnt;
`else
  assign bubbleCount = 32'h0;
  assign stallCount  = 32'h0;
`endif

endmodule
